memb_drain: RTL and testbench

Downstream consumer of the memory-transfer datapath. Once the controller has finished writing results into memory B, `memb_drain` walks all result words in ascending address order. It drives memory B's read address and presents each word on a valid/ready output port. It also accumulates an unsigned checksum of the words it has read and pulses `Done` when the whole memory has been drained.

---
 rtl/memb_drain.sv | 123 ++++++++++++
 tb/tb_memb_drain.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memb_drain.sv
// ----------------------------------------------------------------------------
// memb_drain
//
// Reads every result word out of memory B, starting at address 0 and ending at
// DEPTH-1. Each word is presented on a valid/ready output port. The block keeps
// an unsigned checksum of the words it has captured and pulses Done once the
// last word has been accepted.
//
// Ports
//   clock        in   rising-edge clock
//   Reset        in   asynchronous, active-high reset
//   Start        in   drain request, sampled only in IDLE
//   AddrB        out  [AW] memory B read address
//   DataInB      in   [DW] memory B read data (combinational from AddrB)
//   DOut         out  [DW] registered output word
//   DValid       out  DOut holds a valid word
//   DReady       in   consumer accepts DOut
//   Busy         out  high in every state except IDLE
//   Done         out  one-cycle pulse after the last word is accepted
//   Sum          out  [SW] running unsigned sum of the captured words
//   o_dbg_state  out  [2] current FSM state (IDLE=0 FETCH=1 HOLD=2 DONE=3)
//
// Handshake: a word transfers on a rising edge where DValid && DReady are both
// high. DOut and DValid hold steady until that edge. DValid never depends
// on DReady, and DReady is ignored while DValid is low.
// ----------------------------------------------------------------------------
module memb_drain #(
   parameter int DW    = 8,
   parameter int AW    = 2,
   parameter int DEPTH = 4,
   parameter int SW    = 10
) (
   input  logic          clock,
   input  logic          Reset,
   input  logic          Start,
   output logic [AW-1:0] AddrB,
   input  logic [DW-1:0] DataInB,
   output logic [DW-1:0] DOut,
   output logic          DValid,
   input  logic          DReady,
   output logic          Busy,
   output logic          Done,
   output logic [SW-1:0] Sum,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_dout;
   logic [SW-1:0]   r_sum;
   logic            w_xfer;
   logic            w_last;

   assign w_xfer = (r_state == HOLD) && DReady;
   assign w_last = (r_addr == LP_LAST);

   // State register
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (Start) w_next = FETCH;
         FETCH: w_next = HOLD;
         HOLD:  if (DReady) w_next = w_last ? DONE : FETCH;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: address walk, output word capture and checksum
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         r_addr <= '0;
         r_dout <= '0;
         r_sum  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_addr <= '0;
                  r_sum  <= '0;
               end
            end
            FETCH: begin
               r_dout <= DataInB;
               r_sum  <= r_sum + {{(SW-DW){1'b0}}, DataInB};
            end
            HOLD: begin
               // The last address is terminal: it is left in place until DONE
               // returns the pointer to zero.
               if (w_xfer && !w_last) r_addr <= r_addr + 1'b1;
            end
            DONE: r_addr <= '0;
            default: r_addr <= '0;
         endcase
      end
   end

   // All status outputs decode registered state only
   assign AddrB       = r_addr;
   assign DOut        = r_dout;
   assign DValid      = (r_state == HOLD);
   assign Busy        = (r_state != IDLE);
   assign Done        = (r_state == DONE);
   assign Sum         = r_sum;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memb_drain.sv
// ----------------------------------------------------------------------------
// tb_memb_drain: directed bench for memb_drain with a combinational memory B
// model and hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_memb_drain;

   logic       clock;
   logic       Reset;
   logic       Start;
   logic [1:0] AddrB;
   logic [7:0] DataInB;
   logic [7:0] DOut;
   logic       DValid;
   logic       DReady;
   logic       Busy;
   logic       Done;
   logic [9:0] Sum;
   logic [1:0] dbg_state;

   logic [7:0] mem [4];

   int checks   = 0;
   int failures = 0;

   memb_drain #(.DW(8), .AW(2), .DEPTH(4), .SW(10)) dut (
      .clock       (clock),
      .Reset       (Reset),
      .Start       (Start),
      .AddrB       (AddrB),
      .DataInB     (DataInB),
      .DOut        (DOut),
      .DValid      (DValid),
      .DReady      (DReady),
      .Busy        (Busy),
      .Done        (Done),
      .Sum         (Sum),
      .o_dbg_state (dbg_state)
   );

   // Memory B read is combinational from AddrB
   assign DataInB = mem[AddrB];

   // Clock: low 5-10, rising edges at 10, 20, ...
   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   // Advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_mem(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
   endtask

   // Full drain with `stall` cycles of DReady low on each word.
   task automatic run_drain(input string tag, input int stall,
                            input logic [9:0] final_sum);
      int         cyc;
      logic [9:0] es;
      es = '0;
      Start = 1'b1; DReady = 1'b1;
      tick();                       // E0
      Start = 1'b0; cyc = 0;
      checks++;
      if (Busy !== 1'b1 || DValid !== 1'b0) begin
         failures++;
         $display("FAIL %s_start busy=%b dvalid=%b expected busy=1 dvalid=0", tag, Busy, DValid);
      end
      for (int k = 0; k < 4; k++) begin
         tick(); cyc++;             // FETCH -> HOLD
         es = es + {2'b00, mem[k]};
         checks++;
         if (DValid !== 1'b1 || DOut !== mem[k] || AddrB !== 2'(k) || Sum !== es) begin
            failures++;
            $display("FAIL %s_word%0d dvalid=%b dout=%0d addr=%0d sum=%0d expected 1 %0d %0d %0d",
                     tag, k, DValid, DOut, AddrB, Sum, mem[k], k, es);
         end
         for (int s = 0; s < stall; s++) begin
            DReady = 1'b0;
            tick(); cyc++;
            checks++;
            if (DValid !== 1'b1 || DOut !== mem[k] || AddrB !== 2'(k) || Done !== 1'b0) begin
               failures++;
               $display("FAIL %s_stall%0d_%0d dvalid=%b dout=%0d addr=%0d done=%b expected 1 %0d %0d 0",
                        tag, k, s, DValid, DOut, AddrB, Done, mem[k], k);
            end
         end
         DReady = 1'b1;
         tick(); cyc++;             // handshake edge
         checks++;
         if (k < 3) begin
            if (DValid !== 1'b0 || AddrB !== 2'(k + 1) || Done !== 1'b0) begin
               failures++;
               $display("FAIL %s_xfer%0d dvalid=%b addr=%0d done=%b expected 0 %0d 0",
                        tag, k, DValid, AddrB, Done, k + 1);
            end
         end else begin
            if (DValid !== 1'b0 || AddrB !== 2'd3 || Done !== 1'b1 || cyc != 8 + 4 * stall) begin
               failures++;
               $display("FAIL %s_done dvalid=%b addr=%0d done=%b edge=%0d expected 0 3 1 %0d",
                        tag, DValid, AddrB, Done, cyc, 8 + 4 * stall);
            end
         end
      end
      tick();                       // DONE -> IDLE
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || AddrB !== 2'd0 || Sum !== final_sum) begin
         failures++;
         $display("FAIL %s_end busy=%b done=%b addr=%0d sum=%0d expected 0 0 0 %0d",
                  tag, Busy, Done, AddrB, Sum, final_sum);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; Start = 1'b0; DReady = 1'b1;
      load_mem(8'd3, 8'd1, 8'd255, 8'd8);
      #8 Reset = 1'b1;              // clock is low here, no edge yet
      #1;
      checks++;
      if (AddrB !== 2'd0 || DOut !== 8'd0 || DValid !== 1'b0 || Busy !== 1'b0 ||
          Done !== 1'b0 || Sum !== 10'd0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_async addr=%0d dout=%0d dvalid=%b busy=%b done=%b sum=%0d state=%0d expected all 0",
                  AddrB, DOut, DValid, Busy, Done, Sum, dbg_state);
      end
      tick(); tick();
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (dbg_state !== 2'd0 || AddrB !== 2'd0 || Busy !== 1'b0 || DValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle%0d state=%0d addr=%0d busy=%b dvalid=%b expected 0 0 0 0",
                     i, dbg_state, AddrB, Busy, DValid);
         end
      end
   endtask

   task automatic test_basic_drain();
      load_mem(8'd3, 8'd1, 8'd255, 8'd8);
      run_drain("basic", 0, 10'd267);
   endtask

   task automatic test_backpressure();
      load_mem(8'd3, 8'd1, 8'd255, 8'd8);
      run_drain("bp", 3, 10'd267);
   endtask

   task automatic test_start_while_busy();
      int done_cnt;
      int waited;
      logic [7:0] exp_w [4];
      exp_w[0] = 8'd3; exp_w[1] = 8'd1; exp_w[2] = 8'd255; exp_w[3] = 8'd8;
      load_mem(8'd3, 8'd1, 8'd255, 8'd8);
      done_cnt = 0;
      Start = 1'b1; DReady = 1'b1;
      tick();                       // E0
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (Done === 1'b1) done_cnt++;
         if (e % 2 == 1) begin
            checks++;
            if (DValid !== 1'b1 || DOut !== exp_w[(e - 1) / 2]) begin
               failures++;
               $display("FAIL swb_word%0d dvalid=%b dout=%0d expected 1 %0d",
                        (e - 1) / 2, DValid, DOut, exp_w[(e - 1) / 2]);
            end
         end
      end
      checks++;
      if (done_cnt != 1 || Done !== 1'b1) begin
         failures++;
         $display("FAIL swb_done count=%0d done=%b expected 1 1", done_cnt, Done);
      end
      tick();                       // E9: back to IDLE with Start still high
      checks++;
      if (Busy !== 1'b0 || Sum !== 10'd267) begin
         failures++;
         $display("FAIL swb_idle busy=%b sum=%0d expected 0 267", Busy, Sum);
      end
      tick();                       // E10: second drain accepted
      Start = 1'b0;
      checks++;
      if (Busy !== 1'b1 || Sum !== 10'd0 || AddrB !== 2'd0 || dbg_state !== 2'd1) begin
         failures++;
         $display("FAIL swb_restart busy=%b sum=%0d addr=%0d state=%0d expected 1 0 0 1",
                  Busy, Sum, AddrB, dbg_state);
      end
      waited = 0;
      while (Done !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checks++;
      if (Done !== 1'b1 || Sum !== 10'd267) begin
         failures++;
         $display("FAIL swb_second done=%b sum=%0d after %0d cycles expected 1 267", Done, Sum, waited);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      load_mem(8'd3, 8'd1, 8'd255, 8'd8);
      Start = 1'b1; DReady = 1'b1;
      tick();                       // E0
      Start = 1'b0;
      for (int e = 1; e <= 4; e++) tick();
      DReady = 1'b0;
      tick();                       // E5: HOLD at address 2
      checks++;
      if (dbg_state !== 2'd2 || AddrB !== 2'd2 || Sum !== 10'd259 || DOut !== 8'd255) begin
         failures++;
         $display("FAIL rmid_hold state=%0d addr=%0d sum=%0d dout=%0d expected 2 2 259 255",
                  dbg_state, AddrB, Sum, DOut);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (AddrB !== 2'd0 || DOut !== 8'd0 || DValid !== 1'b0 || Busy !== 1'b0 ||
          Done !== 1'b0 || Sum !== 10'd0) begin
         failures++;
         $display("FAIL rmid_clear addr=%0d dout=%0d dvalid=%b busy=%b done=%b sum=%0d expected all 0",
                  AddrB, DOut, DValid, Busy, Done, Sum);
      end
      tick();
      Reset = 1'b0; DReady = 1'b1;
      tick();
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         failures++;
         $display("FAIL rmid_nodone done=%b busy=%b expected 0 0", Done, Busy);
      end
      run_drain("redrain", 0, 10'd267);
   endtask

   task automatic test_max_sum();
      load_mem(8'd255, 8'd255, 8'd255, 8'd255);
      run_drain("maxsum", 1, 10'd1020);
   endtask

   initial begin
      test_reset();
      test_basic_drain();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid();
      test_max_sum();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
